// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : {PC, instruction} prefetch FIFO between fetch and decode, with
//             first-word-fall-through output and single-cycle flush.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
   parameter int               WIDTH = 32,
   parameter int               DEPTH = 4,
   parameter logic [WIDTH-1:0] NOP   = 32'h00000013
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_pc,
   input  logic [WIDTH-1:0]           in_instr,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_pc,
   output logic [WIDTH-1:0]           out_instr,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;

   logic [WIDTH-1:0] r_pc_mem    [DEPTH];
   logic [WIDTH-1:0] r_instr_mem [DEPTH];
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_CW-1:0]  r_cnt;

   logic w_push;
   logic w_pop;

   assign in_ready  = (r_cnt != c_CW'(DEPTH));
   assign out_valid = (r_cnt != '0);
   assign count     = r_cnt;

   // Flush squashes both handshakes so neither the pair nor the pop takes effect.
   assign w_push = in_valid  & in_ready  & ~flush;
   assign w_pop  = out_valid & out_ready & ~flush;

   assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr]    : '0;
   assign out_instr = out_valid ? r_instr_mem[r_rd_ptr] : NOP;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]    <= in_pc;
         r_instr_mem[r_wr_ptr] <= in_instr;
      end
   end

   // DEPTH is a power of two, so pointer wrap is the natural overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_cnt    <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
         if (w_push && !w_pop)      r_cnt <= r_cnt + c_CW'(1);
         else if (w_pop && !w_push) r_cnt <= r_cnt - c_CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Table-driven bench for fetch_queue with a queue-model scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

   localparam int          WIDTH = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [31:0] in_instr = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [2:0]  count;

   int errors = 0;
   int checks = 0;

   logic [63:0] sb[$];

   typedef struct {
      logic        iv;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fl;
      logic        ordy;
      int          exp_cnt;
   } vec_t;

   vec_t vecs[$];

   fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP(NOP)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                      input logic fl, input logic ordy, input int exp_cnt);
      vecs.push_back('{iv, pc, instr, fl, ordy, exp_cnt});
   endtask

   // Called just after a falling edge: drive, compare head, clock, compare count.
   task automatic step(input vec_t v);
      bit do_push;
      bit do_pop;
      in_valid  = v.iv;
      in_pc     = v.pc;
      in_instr  = v.instr;
      flush     = v.fl;
      out_ready = v.ordy;
      #1;
      check("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) check("head", {out_pc, out_instr}, sb[0]);
      else                check("empty_out", {out_pc, out_instr}, {32'h0, NOP});
      do_push = v.iv && (sb.size() < DEPTH) && !v.fl;
      do_pop  = v.ordy && (sb.size() != 0) && !v.fl;
      @(posedge clk);
      if (v.fl) sb.delete();
      else begin
         if (do_pop)  void'(sb.pop_front());
         if (do_push) sb.push_back({v.pc, v.instr});
      end
      @(negedge clk);
      check("count", 64'(count), 64'(v.exp_cnt));
   endtask

   task automatic run_vecs();
      foreach (vecs[i]) step(vecs[i]);
      vecs.delete();
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_count"}, 64'(count), 64'd0);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_outs"}, {out_pc, out_instr}, {32'h0, NOP});
   endtask

   initial begin
      // Reset held from time 0; check between edges
      #12;
      check_empty("reset");
      @(negedge clk);
      rst = 1'b1;

      // 1: fill, then push attempts while full are ignored
      for (int i = 0; i < 4; i++) add(1'b1, 32'(4*i), 32'hA0 + 32'(i), 1'b0, 1'b0, i + 1);
      add(1'b1, 32'h10, 32'hEE, 1'b0, 1'b0, 4);
      add(1'b1, 32'h10, 32'hEE, 1'b0, 1'b0, 4);
      // 2: drain in order, then idle pop attempt on empty
      for (int i = 0; i < 4; i++) add(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 3 - i);
      add(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 0);
      // 3: two entries, then 10 cycles of simultaneous push/pop across wrap
      add(1'b1, 32'h20, 32'hB0, 1'b0, 1'b0, 1);
      add(1'b1, 32'h24, 32'hB1, 1'b0, 1'b0, 2);
      for (int i = 0; i < 10; i++) add(1'b1, 32'h28 + 32'(4*i), 32'hC0 + 32'(i), 1'b0, 1'b1, 2);
      // 4: fill, then full+pop does not push; retry succeeds
      add(1'b1, 32'h30, 32'hD0, 1'b0, 1'b0, 3);
      add(1'b1, 32'h34, 32'hD1, 1'b0, 1'b0, 4);
      add(1'b1, 32'h40, 32'hD4, 1'b0, 1'b1, 3);
      add(1'b1, 32'h40, 32'hD4, 1'b0, 1'b0, 4);
      // 5: flush with push and pop in the same cycle, then push after flush
      add(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 3);
      add(1'b1, 32'h80, 32'hE0, 1'b1, 1'b1, 0);
      add(1'b1, 32'h100, 32'hF0, 1'b0, 1'b0, 1);
      add(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 0);
      // 6 setup: three entries before reset
      add(1'b1, 32'h140, 32'h11, 1'b0, 1'b0, 1);
      add(1'b1, 32'h144, 32'h12, 1'b0, 1'b0, 2);
      add(1'b1, 32'h148, 32'h13, 1'b0, 1'b0, 3);
      run_vecs();

      // 6: asynchronous reset between edges
      in_valid = 1'b0;
      out_ready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check_empty("async_rst");
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      add(1'b1, 32'h200, 32'h77, 1'b0, 1'b0, 1);
      add(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 0);
      run_vecs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch queue directly downstream of the PC/instruction-ROM fetch stage.
- Captures {PC, instruction} pairs from fetch into a small FIFO and presents them to decode with a valid/ready handshake.
- Decouples fetch from decode stalls.
- Supports a single-cycle flush on taken branch/jump, which discards every queued entry.

Parameters:
- WIDTH, 32, data width of PC and instruction fields.
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- NOP, 32'h00000013, instruction value driven on out_instr when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- in_valid  input  1  fetch presents a valid pair this cycle.
- in_ready  output  1  queue accepts a pair this cycle.
- in_pc  input  WIDTH  PC of the incoming instruction.
- in_instr  input  WIDTH  instruction word from ROM.
- flush  input  1  discard all entries (taken branch/jump).
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  WIDTH  PC of the head entry.
- out_instr  output  WIDTH  instruction of the head entry.
- count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage:
  - DEPTH-entry circular buffer of {pc, instr}.
  - Read pointer rd_ptr and write pointer wr_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH (DEPTH-1 -> 0).
  - Occupancy register cnt drives count.
- Reset (rst=0, asynchronous):
  - rd_ptr=0, wr_ptr=0, cnt=0.
  - Therefore out_valid=0, in_ready=1, count=0, out_pc=0, out_instr=NOP.
  - Storage contents need not be reset.
  - Reset asserted mid-operation drops all entries immediately; the first rising edge after rst returns to 1 behaves as from an empty queue.
- Combinational outputs:
  - in_ready = (cnt != DEPTH).
  - out_valid = (cnt != 0).
  - out_pc/out_instr = entry[rd_ptr] when out_valid=1, else 0/NOP.
  - First-word-fall-through: an entry written at edge N is visible on the outputs after edge N.
- Events per rising edge (flush=0):
  - push = in_valid & in_ready: write {in_pc, in_instr} at wr_ptr; wr_ptr+1.
  - pop = out_valid & out_ready: rd_ptr+1.
  - cnt update: push only +1; pop only -1; both or neither, unchanged.
- Latency: write to head visibility is 1 cycle minimum. There is no combinational in-to-out bypass; an empty queue never forwards the same cycle.
- Full (cnt=DEPTH):
  - in_ready=0, so in_valid is ignored even if out_ready=1 in the same cycle (no same-cycle push on pop from full).
  - The next cycle has cnt=DEPTH-1 and in_ready=1.
- Empty (cnt=0):
  - out_ready is ignored and no pop occurs.
  - A push in the same cycle proceeds normally, giving cnt=1 next cycle.
- Flush (flush=1 at a rising edge):
  - rd_ptr=0, wr_ptr=0, cnt=0.
  - Any push or pop in the same cycle is discarded: the incoming pair is not stored and the pop is not counted.
  - Flush has priority over all other events.
  - in_ready stays combinationally driven from cnt during the flush cycle; fetch must treat its own pair as squashed.
- Stability: while out_valid=1 and out_ready=0, out_pc/out_instr hold until a pop, flush or reset.
- Overflow/underflow are structurally impossible; cnt never exceeds DEPTH or goes below 0.

Test Plan:
1. Reset then fill.
   - Stimulus: rst=0 then 1; push pc=0x0/0x4/0x8/0xC with instr=0xA0..0xA3, out_ready=0.
   - Response: count=1,2,3,4; in_ready=0 after the 4th push; head out_pc=0x0, out_instr=0xA0.
   - Then hold in_valid=1 with pc=0x10 for 2 cycles: count stays 4, pc=0x10 never appears.
2. Drain in order.
   - Stimulus: from full, out_ready=1, in_valid=0.
   - Response: out_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles; then out_valid=0, out_instr=0x00000013, count=0.
3. Simultaneous push/pop and wrap.
   - Stimulus: cnt=2; in_valid=1 and out_ready=1 for 10 cycles, pcs incrementing by 4.
   - Response: count stays 2; outputs in strict push order across pointer wrap; no duplicates or drops.
4. Full plus pop.
   - Stimulus: cnt=4, in_valid=1 (pc=0x40), out_ready=1.
   - Response: pop only, count=3, pc=0x40 not stored.
   - Next cycle push of pc=0x40 succeeds and count=4.
5. Flush priority.
   - Stimulus: cnt=3, flush=1 with in_valid=1 (pc=0x80) and out_ready=1.
   - Response: next cycle count=0, out_valid=0, out_instr=0x00000013; pc=0x80 never emerges.
   - Subsequent push of pc=0x100 appears as head one cycle later.
6. Asynchronous reset mid-operation.
   - Stimulus: cnt=3, drive rst=0 between clock edges.
   - Response: count=0, out_valid=0, in_ready=1 before the next edge.
   - After release, a push of pc=0x200 is the first head.
